// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving a shared 4:1 mux with valid/ready output
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module mux4_rr_arbiter #(
  parameter int DW    = 1,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [4*DW-1:0] din,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] dout,
  output logic [1:0]    sel,
  output logic [3:0]    gnt,
  output logic [3:0]    ack
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nxt;
  logic [1:0] sel_q, sel_nxt;
  logic [3:0] gnt_q, gnt_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [3:0] beat_cnt, beat_cnt_nxt;

  logic       found;
  logic [1:0] pick;
  logic [1:0] base;
  logic [1:0] cand;
  logic       valid_raw;
  logic       beat;

  // Search starts just past the last holder so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    cand  = 2'd0;
`ifdef ARB_FIXED_PRIO_EN
    base  = 2'd0;
`else
    base  = ptr + 2'd1;
`endif
    for (int k = 0; k < 4; k++) begin
      cand = base + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign valid_raw = (state == BUSY) && req[sel_q];
  assign beat      = valid_raw && out_ready;

  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel_q;
    gnt_nxt      = gnt_q;
    ptr_nxt      = ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          sel_nxt      = pick;
          gnt_nxt      = 4'b0001 << pick;
          beat_cnt_nxt = 4'd0;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        if (!req[sel_q] || (beat && beat_cnt == 4'(BURST - 1))) begin
          state_nxt = IDLE;
          gnt_nxt   = 4'b0000;
          ptr_nxt   = sel_q;
        end
        if (beat) begin
          beat_cnt_nxt = beat_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= 2'd0;
      gnt_q    <= 4'b0000;
      ptr      <= 2'd3;
      beat_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      sel_q    <= sel_nxt;
      gnt_q    <= gnt_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // All outputs read as reset values while rst is high, so no ack leaks in that cycle.
  always_comb begin
    out_valid = 1'b0;
    dout      = '0;
    ack       = 4'b0000;
    sel       = 2'd0;
    gnt       = 4'b0000;
    if (!rst) begin
      out_valid = valid_raw;
      sel       = sel_q;
      gnt       = gnt_q;
      if (valid_raw) begin
        dout = din[int'(sel_q)*DW +: DW];
      end
      if (beat) begin
        ack = 4'b0001 << sel_q;
      end
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - randomized and directed checks of mux4_rr_arbiter against a beat-level model
module tb_mux4_rr_arbiter;
  localparam int DW    = 1;
  localparam int BURST = 4;
  localparam int VW    = 11 + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [4*DW-1:0] din;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] dout;
  logic [1:0]    sel;
  logic [3:0]    gnt;
  logic [3:0]    ack;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: who holds the grant, how many beats it has taken, who held it last.
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_cnt;

  mux4_rr_arbiter #(.DW(DW), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .out_ready(out_ready),
    .out_valid(out_valid), .dout(dout), .sel(sel), .gnt(gnt), .ack(ack)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [VW-1:0] expect_vec();
    logic          v;
    logic [3:0]    g;
    logic [1:0]    s;
    logic [DW-1:0] d;
    logic [3:0]    a;
    v = !rst && m_busy && req[m_sel];
    g = (!rst && m_busy) ? 4'(1 << m_sel) : 4'b0000;
    s = rst ? 2'd0 : 2'(m_sel);
    d = v ? din[m_sel*DW +: DW] : '0;
    a = (v && out_ready) ? 4'(1 << m_sel) : 4'b0000;
    return {g, s, v, d, a};
  endfunction

  task automatic model_tick();
    bit found;
    int i;
    if (rst) begin
      m_busy = 0; m_sel = 0; m_ptr = 3; m_cnt = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
        i = k - 1;
`else
        i = (m_ptr + k) % 4;
`endif
        if (!found && req[i]) begin
          found = 1; m_busy = 1; m_sel = i; m_cnt = 0;
        end
      end
    end else if (!req[m_sel]) begin
      m_busy = 0; m_ptr = m_sel;
    end else if (out_ready) begin
      m_cnt++;
      if (m_cnt == BURST) begin
        m_busy = 0; m_ptr = m_sel;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; out_ready = 1'b1; din = 4'b1010;
    m_busy = 0; m_sel = 0; m_ptr = 3; m_cnt = 0;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_cmp++;
      if ({gnt, sel, out_valid, ack} !== 11'b0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got gnt=%b sel=%b vld=%b ack=%b, want all zero", c, gnt, sel, out_valid, ack);
      end
      tick();
    end
    rst = 1'b0;
    settle();
    n_cmp++;
    if (gnt !== 4'b0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got gnt=%b vld=%b, want 0000/0", gnt, out_valid);
    end
    tick();
    settle();
    n_cmp++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_first_grant: got gnt=%b sel=%b, want 0001/00", gnt, sel);
    end
    tick();
  endtask

  task automatic test_rotation();
    int order[5];
    int n_order;
    int acks[4];
    int idles;
    logic [3:0] prev_gnt;
    int exp_order[5];
    int exp_acks[4];
`ifdef ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
    exp_acks  = '{16, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
    exp_acks  = '{4, 4, 4, 4};
`endif
    n_order = 0; idles = 0; prev_gnt = 4'b0000;
    acks = '{0, 0, 0, 0};
    order = '{-1, -1, -1, -1, -1};
    req = 4'b1111; out_ready = 1'b1;
    apply_reset();
    for (int c = 0; c < 22; c++) begin
      din = 4'($urandom);
      settle();
      n_cmp++;
      if ({gnt, sel, out_valid, dout, ack} !== expect_vec()) begin
        n_fail++;
        $display("FAIL rotation_model cycle %0d: got %b want %b", c, {gnt, sel, out_valid, dout, ack}, expect_vec());
      end
      if (gnt !== 4'b0000 && prev_gnt === 4'b0000 && n_order < 5) begin
        order[n_order] = int'(sel);
        n_order++;
      end
      if (c < 21) begin
        if (gnt === 4'b0000) idles++;
        for (int i = 0; i < 4; i++) if (ack[i] === 1'b1) acks[i]++;
      end
      prev_gnt = gnt;
      tick();
    end
    n_cmp++;
    if (order != exp_order) begin
      n_fail++;
      $display("FAIL rotation_order: got %0d,%0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d,%0d",
               order[0], order[1], order[2], order[3], order[4],
               exp_order[0], exp_order[1], exp_order[2], exp_order[3], exp_order[4]);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (acks[i] != exp_acks[i]) begin
        n_fail++;
        $display("FAIL rotation_acks[%0d]: got %0d want %0d", i, acks[i], exp_acks[i]);
      end
    end
    n_cmp++;
    if (idles != 5) begin
      n_fail++;
      $display("FAIL rotation_idles: got %0d want 5", idles);
    end
  endtask

  task automatic test_backpressure();
    req = 4'b0100; din = 4'b0100; out_ready = 1'b0;
    apply_reset();
    tick();
    for (int c = 1; c <= 8; c++) begin
      out_ready = (c >= 4);
      settle();
      n_cmp++;
      if (c <= 3 && {gnt, sel, out_valid, dout, ack} !== {4'b0100, 2'd2, 1'b1, 1'b1, 4'b0000}) begin
        n_fail++;
        $display("FAIL backpressure_stall cycle %0d: got gnt=%b sel=%b vld=%b dout=%b ack=%b", c, gnt, sel, out_valid, dout, ack);
      end else if (c >= 4 && c <= 7 && {gnt, ack} !== {4'b0100, 4'b0100}) begin
        n_fail++;
        $display("FAIL backpressure_beat cycle %0d: got gnt=%b ack=%b want 0100/0100", c, gnt, ack);
      end else if (c == 8 && {gnt, out_valid} !== {4'b0000, 1'b0}) begin
        n_fail++;
        $display("FAIL backpressure_idle: got gnt=%b vld=%b want 0000/0", gnt, out_valid);
      end
      tick();
    end
  endtask

  task automatic test_early_drop();
    req = 4'b0011; din = 4'b0011; out_ready = 1'b1;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 3) req = 4'b0010;
      settle();
      n_cmp++;
      if ({gnt, sel, out_valid, dout, ack} !== expect_vec()) begin
        n_fail++;
        $display("FAIL early_drop_model cycle %0d: got %b want %b", c, {gnt, sel, out_valid, dout, ack}, expect_vec());
      end
      n_cmp++;
      if ((c == 1 || c == 2) && {gnt, ack} !== 8'b0001_0001) begin
        n_fail++;
        $display("FAIL early_drop_beat cycle %0d: got gnt=%b ack=%b want 0001/0001", c, gnt, ack);
      end else if (c == 3 && {gnt, out_valid, ack} !== {4'b0001, 1'b0, 4'b0000}) begin
        n_fail++;
        $display("FAIL early_drop_drop: got gnt=%b vld=%b ack=%b want 0001/0/0000", gnt, out_valid, ack);
      end else if (c == 4 && gnt !== 4'b0000) begin
        n_fail++;
        $display("FAIL early_drop_idle: got gnt=%b want 0000", gnt);
      end else if (c == 5 && {gnt, ack} !== 8'b0010_0010) begin
        n_fail++;
        $display("FAIL early_drop_regrant: got gnt=%b ack=%b want 0010/0010", gnt, ack);
      end
      tick();
    end
    req = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      settle();
      n_cmp++;
      if ({gnt, sel, out_valid, dout, ack} !== expect_vec()) begin
        n_fail++;
        $display("FAIL early_drop_after cycle %0d: got %b want %b", c, {gnt, sel, out_valid, dout, ack}, expect_vec());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    req = 4'b1111; out_ready = 1'b1; din = 4'b1111;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      settle();
      n_cmp++;
      if ({gnt, sel, out_valid, dout, ack} !== expect_vec()) begin
        n_fail++;
        $display("FAIL midreset_model cycle %0d: got %b want %b", c, {gnt, sel, out_valid, dout, ack}, expect_vec());
      end
      tick();
    end
    rst = 1'b1;
    settle();
    n_cmp++;
    if ({gnt, sel, out_valid, dout, ack} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got gnt=%b sel=%b vld=%b dout=%b ack=%b want zero", gnt, sel, out_valid, dout, ack);
    end
    tick();
    rst = 1'b0;
    settle();
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_idle: got gnt=%b want 0000", gnt);
    end
    tick();
    settle();
    n_cmp++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      n_fail++;
      $display("FAIL midreset_regrant: got gnt=%b sel=%b want 0001/00", gnt, sel);
    end
    tick();
  endtask

  task automatic test_random();
    req = 4'($urandom);
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      din = 4'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      settle();
      n_cmp++;
      if ({gnt, sel, out_valid, dout, ack} !== expect_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b want %b (req=%b rdy=%b rst=%b)", c, {gnt, sel, out_valid, dout, ack}, expect_vec(), req, out_ready, rst);
      end
      n_cmp++;
      if (ack !== 4'b0000 && (ack & gnt) !== ack) begin
        n_fail++;
        $display("FAIL random_ack_in_gnt cycle %0d: got ack=%b gnt=%b", c, ack, gnt);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_backpressure();
    test_early_drop();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
